// File: rtl/masked_sbox_scheduler.sv
// Issue/tag controller for the shared masked 3-stage GF(2^8) inverter (control path only, no share data).
// Latency: issue is combinational with the grant; a tag reaches out_rsp_* LATENCY cycles after issue.
// Backpressure: requests stall only on arbitration loss, missing randomness or sticky error; responses are never stalled.
module masked_sbox_scheduler #(
    parameter int LATENCY     = 3,
    parameter bit KS_PRIORITY = 1'b1
) (
    input  logic       in_clock,
    input  logic       in_reset,
    input  logic       in_st_valid,
    input  logic [3:0] in_st_index,
    output logic       out_st_ready,
    input  logic       in_ks_valid,
    input  logic [1:0] in_ks_index,
    output logic       out_ks_ready,
    input  logic       in_rand_valid,
    output logic       out_rand_step,
    output logic       out_issue,
    output logic       out_sel_ks,
    output logic       out_rsp_valid,
    output logic       out_rsp_is_ks,
    output logic [3:0] out_rsp_index,
    output logic       out_busy,
    output logic       out_rand_err
);

    typedef struct packed {
        logic       vld;
        logic       is_ks;
        logic [3:0] index;
    } tag_t;

    tag_t [LATENCY-1:0] tag_pipe;
    logic               live;      // low for the first cycle after reset release
    logic               rr_ks;     // 1: ks wins the next tie (round-robin mode only)
    logic               sel_last;  // mux select held between issues
    logic               rand_err;
    logic               any_vld;
    logic               grant_ks;
    logic               grant_any;
    logic               tie;
    logic               issue;
    tag_t               tag_in;

    // Any live operand inside the inverter stages.
    always_comb begin
        any_vld = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            any_vld = any_vld | tag_pipe[i].vld;
        end
    end

    // Arbitration and issue qualification; a lone requester always wins.
    always_comb begin
        tie       = in_st_valid & in_ks_valid;
        grant_any = in_st_valid | in_ks_valid;
        grant_ks  = 1'b0;
        if (tie) begin
            grant_ks = KS_PRIORITY ? 1'b1 : rr_ks;
        end else if (in_ks_valid) begin
            grant_ks = 1'b1;
        end
        issue  = grant_any & live & in_rand_valid & ~rand_err;
        tag_in = '0;
        if (issue) begin
            tag_in.vld   = 1'b1;
            tag_in.is_ks = grant_ks;
            tag_in.index = grant_ks ? {2'b00, in_ks_index} : in_st_index;
        end
    end

    assign out_issue     = issue;
    assign out_st_ready  = issue & ~grant_ks;
    assign out_ks_ready  = issue & grant_ks;
    assign out_sel_ks    = issue ? grant_ks : sel_last;
    assign out_rand_step = issue | any_vld;
    assign out_busy      = issue | any_vld;
    assign out_rand_err  = rand_err;
    assign out_rsp_valid = tag_pipe[LATENCY-1].vld;
    assign out_rsp_is_ks = tag_pipe[LATENCY-1].is_ks;
    assign out_rsp_index = tag_pipe[LATENCY-1].index;

    // Tag pipe shifts every cycle in lockstep with the inverter; control state updates alongside.
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            tag_pipe <= '0;
            live     <= 1'b0;
            rr_ks    <= 1'b0;
            sel_last <= 1'b0;
            rand_err <= 1'b0;
        end else begin
            tag_pipe[0] <= tag_in;
            for (int i = 1; i < LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            live <= 1'b1;
            if (issue) begin
                sel_last <= grant_ks;
            end
            if (issue && tie) begin
                rr_ks <= ~grant_ks;
            end
            // Stages holding live data need fresh masks every cycle.
            if (!in_rand_valid && any_vld) begin
                rand_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_masked_sbox_scheduler.sv
module tb_masked_sbox_scheduler;

    logic       clk;
    logic       rst_n;
    logic       st_valid;
    logic [3:0] st_index;
    logic       ks_valid;
    logic [1:0] ks_index;
    logic       rand_valid;
    logic       sel_rr;

    logic       p_st_rdy, p_ks_rdy, p_step, p_issue, p_sel, p_rv, p_rks, p_busy, p_err;
    logic [3:0] p_ridx;
    logic       r_st_rdy, r_ks_rdy, r_step, r_issue, r_sel, r_rv, r_rks, r_busy, r_err;
    logic [3:0] r_ridx;

    logic       m_st_rdy, m_ks_rdy, m_step, m_issue, m_sel, m_rv, m_rks, m_busy, m_err;
    logic [3:0] m_ridx;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] st_q[$];
    logic [1:0] ks_q[$];
    logic [4:0] exp_q[$];

    masked_sbox_scheduler #(.LATENCY(3), .KS_PRIORITY(1'b1)) dut_pri (
        .in_clock(clk), .in_reset(rst_n),
        .in_st_valid(st_valid), .in_st_index(st_index), .out_st_ready(p_st_rdy),
        .in_ks_valid(ks_valid), .in_ks_index(ks_index), .out_ks_ready(p_ks_rdy),
        .in_rand_valid(rand_valid), .out_rand_step(p_step), .out_issue(p_issue),
        .out_sel_ks(p_sel), .out_rsp_valid(p_rv), .out_rsp_is_ks(p_rks),
        .out_rsp_index(p_ridx), .out_busy(p_busy), .out_rand_err(p_err)
    );

    masked_sbox_scheduler #(.LATENCY(3), .KS_PRIORITY(1'b0)) dut_rr (
        .in_clock(clk), .in_reset(rst_n),
        .in_st_valid(st_valid), .in_st_index(st_index), .out_st_ready(r_st_rdy),
        .in_ks_valid(ks_valid), .in_ks_index(ks_index), .out_ks_ready(r_ks_rdy),
        .in_rand_valid(rand_valid), .out_rand_step(r_step), .out_issue(r_issue),
        .out_sel_ks(r_sel), .out_rsp_valid(r_rv), .out_rsp_is_ks(r_rks),
        .out_rsp_index(r_ridx), .out_busy(r_busy), .out_rand_err(r_err)
    );

    assign m_st_rdy = sel_rr ? r_st_rdy : p_st_rdy;
    assign m_ks_rdy = sel_rr ? r_ks_rdy : p_ks_rdy;
    assign m_step   = sel_rr ? r_step   : p_step;
    assign m_issue  = sel_rr ? r_issue  : p_issue;
    assign m_sel    = sel_rr ? r_sel    : p_sel;
    assign m_rv     = sel_rr ? r_rv     : p_rv;
    assign m_rks    = sel_rr ? r_rks    : p_rks;
    assign m_ridx   = sel_rr ? r_ridx   : p_ridx;
    assign m_busy   = sel_rr ? r_busy   : p_busy;
    assign m_err    = sel_rr ? r_err    : p_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // All outputs of the selected instance must be zero.
    task automatic check_quiet(input string tag);
        check_eq({tag, " st_rdy"}, 32'(m_st_rdy), 0);
        check_eq({tag, " ks_rdy"}, 32'(m_ks_rdy), 0);
        check_eq({tag, " issue"},  32'(m_issue), 0);
        check_eq({tag, " sel"},    32'(m_sel), 0);
        check_eq({tag, " rv"},     32'(m_rv), 0);
        check_eq({tag, " rks"},    32'(m_rks), 0);
        check_eq({tag, " ridx"},   32'(m_ridx), 0);
        check_eq({tag, " step"},   32'(m_step), 0);
        check_eq({tag, " busy"},   32'(m_busy), 0);
        check_eq({tag, " err"},    32'(m_err), 0);
    endtask

    // Hold reset two cycles, check outputs, release 1 time unit after a rising edge (start of cycle 0).
    task automatic do_reset(input string nm);
        st_valid   = 1'b0;
        st_index   = '0;
        ks_valid   = 1'b0;
        ks_index   = '0;
        rand_valid = 1'b1;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet({nm, " in_reset"});
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Runs queued requests; exp_q lists grants {is_ks, index} expected at cycles 1..N.
    // Randomness is withheld for cycles off_lo..off_hi; err_from < 0 means the error never sets.
    task automatic run_case(input string nm, input bit rr, input int ncyc,
                            input int off_lo, input int off_hi, input int err_from);
        int         n_exp;
        logic [4:0] ea[$];
        logic       exp_iss, exp_rv, exp_busy, sel_hold;
        string      t;
        ea       = exp_q;
        n_exp    = ea.size();
        sel_hold = 1'b0;
        sel_rr   = rr;
        do_reset(nm);
        for (int c = 0; c < ncyc; c++) begin
            st_valid   = (st_q.size() > 0);
            st_index   = st_valid ? st_q[0] : 4'd0;
            ks_valid   = (ks_q.size() > 0);
            ks_index   = ks_valid ? ks_q[0] : 2'd0;
            rand_valid = !(c >= off_lo && c <= off_hi);
            @(negedge clk);
            t        = $sformatf("%s c%0d", nm, c);
            exp_iss  = (c >= 1 && c <= n_exp);
            exp_rv   = (n_exp > 0 && c >= 4 && c <= n_exp + 3);
            exp_busy = exp_iss || (n_exp > 0 && c >= 2 && c <= n_exp + 3);
            check_eq({t, " issue"}, 32'(m_issue), 32'(exp_iss));
            if (exp_iss) begin
                sel_hold = ea[c-1][4];
                check_eq({t, " st_rdy"}, 32'(m_st_rdy), 32'(!ea[c-1][4]));
                check_eq({t, " ks_rdy"}, 32'(m_ks_rdy), 32'(ea[c-1][4]));
            end else begin
                check_eq({t, " st_rdy"}, 32'(m_st_rdy), 0);
                check_eq({t, " ks_rdy"}, 32'(m_ks_rdy), 0);
            end
            check_eq({t, " sel"}, 32'(m_sel), 32'(sel_hold));
            check_eq({t, " rv"}, 32'(m_rv), 32'(exp_rv));
            if (exp_rv) begin
                check_eq({t, " rks"},  32'(m_rks),  32'(ea[c-4][4]));
                check_eq({t, " ridx"}, 32'(m_ridx), 32'(ea[c-4][3:0]));
            end
            check_eq({t, " busy"}, 32'(m_busy), 32'(exp_busy));
            check_eq({t, " step"}, 32'(m_step), 32'(exp_busy));
            check_eq({t, " err"},  32'(m_err),  32'(err_from >= 0 && c >= err_from));
            if (m_st_rdy && st_q.size() > 0) void'(st_q.pop_front());
            if (m_ks_rdy && ks_q.size() > 0) void'(ks_q.pop_front());
            @(posedge clk);
            #1;
        end
        st_q.delete();
        ks_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst_n      = 1'b0;
        sel_rr     = 1'b0;
        st_valid   = 1'b0;
        st_index   = '0;
        ks_valid   = 1'b0;
        ks_index   = '0;
        rand_valid = 1'b0;

        // State bytes 0..15 back to back: issues 1..16, responses 4..19, idle from 20.
        for (int i = 0; i < 16; i++) begin
            st_q.push_back(4'(i));
            exp_q.push_back({1'b0, 4'(i)});
        end
        run_case("st_only", 1'b0, 22, -1, -1, -1);

        // Key schedule priority: ks 0..3 first, then st 8..11.
        for (int i = 0; i < 4; i++) begin
            st_q.push_back(4'(8 + i));
            ks_q.push_back(2'(i));
        end
        exp_q = '{5'h10, 5'h11, 5'h12, 5'h13, 5'h08, 5'h09, 5'h0A, 5'h0B};
        run_case("ks_pri", 1'b0, 14, -1, -1, -1);

        // Round-robin: tie starts with state, then alternates.
        for (int i = 0; i < 4; i++) begin
            st_q.push_back(4'(i));
            ks_q.push_back(2'(i));
        end
        exp_q = '{5'h00, 5'h10, 5'h01, 5'h11, 5'h02, 5'h12, 5'h03, 5'h13};
        run_case("rr_alt", 1'b1, 14, -1, -1, -1);

        // Lone key requester under round-robin, index zero-extended; select holds 1 afterwards.
        ks_q  = '{2'd3, 2'd2, 2'd1};
        exp_q = '{5'h13, 5'h12, 5'h11};
        run_case("ks_only", 1'b1, 9, -1, -1, -1);

        // Randomness drops at cycle 3 with two tags in flight: sticky error, tags still drain.
        for (int i = 0; i < 6; i++) st_q.push_back(4'(i));
        exp_q = '{5'h00, 5'h01};
        run_case("rand_err", 1'b0, 10, 3, 3, 4);

        // Randomness absent with empty pipe: no issue, no step, no error.
        st_q  = '{4'd1, 4'd2};
        ks_q  = '{2'd0};
        run_case("rand_idle", 1'b1, 6, 0, 100, -1);

        // Reset dropped mid-operation at cycle 2: outputs zero at once, no response afterwards.
        sel_rr = 1'b0;
        do_reset("mid_rst");
        st_valid = 1'b1;
        st_index = 4'd0;
        @(negedge clk);
        check_eq("mid_rst c0 issue", 32'(m_issue), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("mid_rst c1 issue", 32'(m_issue), 1);
        check_eq("mid_rst c1 st_rdy", 32'(m_st_rdy), 1);
        @(posedge clk);
        #1 st_index = 4'd1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_quiet("mid_rst c2");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        st_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check_quiet($sformatf("mid_rst post%0d", c));
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
